// File: rtl/module_ctrl_calc.sv
// Sequencing FSM for the keypad-multiplier calculator.
// Builds operand A and operand B from decimal keypad digits, launches the multiplier with a
// one-cycle start pulse, waits for its done signal (with a timeout) and drives the flags that
// steer the 7-segment display between the operand under entry and the product.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   rst        asynchronous, active-high reset
//   key_valid  one-cycle pulse qualifying key_code
//   key_code   0x0-0x9 digit, 0xA enter, 0xB clear, 0xC-0xF ignored
//   mul_done   multiplier result valid, only looked at while waiting
//   num_1      operand A, unsigned binary
//   num_2      operand B, unsigned binary
//   mul_start  one-cycle start pulse to the multiplier
//   listo_1    operand A complete
//   listo_2    operand B complete
//   listo      product valid for display
//   busy       multiplication in flight
//   error      multiplier timeout
module module_ctrl_calc #(
    parameter int unsigned MAX_DIGITS  = 3,
    parameter int unsigned MUL_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       mul_done,
    output logic [7:0] num_1,
    output logic [7:0] num_2,
    output logic       mul_start,
    output logic       listo_1,
    output logic       listo_2,
    output logic       listo,
    output logic       busy,
    output logic       error
);

    localparam int unsigned CW = $clog2(MAX_DIGITS + 1);
    localparam int unsigned TW = $clog2(MUL_TIMEOUT) + 1;

    typedef enum logic [2:0] {
        StA,
        StB,
        StStart,
        StWait,
        StRes,
        StErr
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      num_1_q, num_1_d;
    logic [7:0]      num_2_q, num_2_d;
    logic [CW-1:0]   cnt_a_q, cnt_a_d;
    logic [CW-1:0]   cnt_b_q, cnt_b_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            mul_start_q, listo_1_q, listo_2_q, listo_q, busy_q, error_q;

    logic            is_digit, is_enter, is_clear;
    logic [11:0]     tmp_a, tmp_b;
    logic            ok_a, ok_b;

    assign is_digit = key_valid && (key_code <= 4'd9);
    assign is_enter = key_valid && (key_code == 4'hA);
    assign is_clear = key_valid && (key_code == 4'hB);

    // Candidate accumulator values at 12 bits so overflow past 255 is visible.
    assign tmp_a = 12'(num_1_q) * 12'd10 + 12'(key_code);
    assign tmp_b = 12'(num_2_q) * 12'd10 + 12'(key_code);
    assign ok_a  = (cnt_a_q < CW'(MAX_DIGITS)) && (tmp_a <= 12'd255);
    assign ok_b  = (cnt_b_q < CW'(MAX_DIGITS)) && (tmp_b <= 12'd255);

    always_comb begin
        state_d = state_q;
        num_1_d = num_1_q;
        num_2_d = num_2_q;
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        tmo_d   = tmo_q;

        case (state_q)
            StA: begin
                if (is_clear) begin
                    num_1_d = '0;
                    num_2_d = '0;
                    cnt_a_d = '0;
                    cnt_b_d = '0;
                    tmo_d   = '0;
                end else if (is_digit && ok_a) begin
                    num_1_d = tmp_a[7:0];
                    cnt_a_d = cnt_a_q + CW'(1);
                end else if (is_enter && (cnt_a_q != '0)) begin
                    state_d = StB;
                end
            end
            StB: begin
                if (is_clear) begin
                    state_d = StA;
                    num_1_d = '0;
                    num_2_d = '0;
                    cnt_a_d = '0;
                    cnt_b_d = '0;
                    tmo_d   = '0;
                end else if (is_digit && ok_b) begin
                    num_2_d = tmp_b[7:0];
                    cnt_b_d = cnt_b_q + CW'(1);
                end else if (is_enter && (cnt_b_q != '0)) begin
                    state_d = StStart;
                    tmo_d   = '0;
                end
            end
            StStart: begin
                state_d = StWait;
            end
            StWait: begin
                // Abort takes priority; done beats a same-cycle timeout.
                if (is_clear) begin
                    state_d = StA;
                    num_1_d = '0;
                    num_2_d = '0;
                    cnt_a_d = '0;
                    cnt_b_d = '0;
                    tmo_d   = '0;
                end else if (mul_done) begin
                    state_d = StRes;
                end else if (tmo_q == TW'(MUL_TIMEOUT - 1)) begin
                    state_d = StErr;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            StRes: begin
                if (is_clear || is_digit) begin
                    state_d = StA;
                    num_2_d = '0;
                    cnt_b_d = '0;
                    tmo_d   = '0;
                    // A digit starts a new calculation as the first digit of A.
                    num_1_d = is_digit ? {4'b0000, key_code} : 8'd0;
                    cnt_a_d = is_digit ? CW'(1) : '0;
                end
            end
            StErr: begin
                if (is_clear) begin
                    state_d = StA;
                    num_1_d = '0;
                    num_2_d = '0;
                    cnt_a_d = '0;
                    cnt_b_d = '0;
                    tmo_d   = '0;
                end
            end
            default: begin
                state_d = StA;
                num_1_d = '0;
                num_2_d = '0;
                cnt_a_d = '0;
                cnt_b_d = '0;
                tmo_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StA;
            num_1_q     <= '0;
            num_2_q     <= '0;
            cnt_a_q     <= '0;
            cnt_b_q     <= '0;
            tmo_q       <= '0;
            mul_start_q <= 1'b0;
            listo_1_q   <= 1'b0;
            listo_2_q   <= 1'b0;
            listo_q     <= 1'b0;
            busy_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_1_q     <= num_1_d;
            num_2_q     <= num_2_d;
            cnt_a_q     <= cnt_a_d;
            cnt_b_q     <= cnt_b_d;
            tmo_q       <= tmo_d;
            // Flags decoded from the next state so they line up with state_q.
            mul_start_q <= (state_d == StStart);
            listo_1_q   <= (state_d == StB) || (state_d == StStart) ||
                           (state_d == StWait) || (state_d == StRes);
            listo_2_q   <= (state_d == StStart) || (state_d == StWait) || (state_d == StRes);
            listo_q     <= (state_d == StRes);
            busy_q      <= (state_d == StStart) || (state_d == StWait);
            error_q     <= (state_d == StErr);
        end
    end

    assign num_1     = num_1_q;
    assign num_2     = num_2_q;
    assign mul_start = mul_start_q;
    assign listo_1   = listo_1_q;
    assign listo_2   = listo_2_q;
    assign listo     = listo_q;
    assign busy      = busy_q;
    assign error     = error_q;

endmodule

// File: tb/tb_module_ctrl_calc.sv
// Testbench for module_ctrl_calc: table-driven key sequences plus hand-written
// timeout, abort and asynchronous-reset sequences.
module tb_module_ctrl_calc;

    localparam int unsigned MUL_TIMEOUT = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic       mul_done = 1'b0;
    logic [7:0] num_1, num_2;
    logic       mul_start, listo_1, listo_2, listo, busy, error;

    int errors = 0;
    int checks = 0;

    module_ctrl_calc #(
        .MAX_DIGITS (3),
        .MUL_TIMEOUT(MUL_TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_valid(key_valid),
        .key_code (key_code),
        .mul_done (mul_done),
        .num_1    (num_1),
        .num_2    (num_2),
        .mul_start(mul_start),
        .listo_1  (listo_1),
        .listo_2  (listo_2),
        .listo    (listo),
        .busy     (busy),
        .error    (error)
    );

    always #5 clk = ~clk;

    // Packed output order: {num_1, num_2, mul_start, listo_1, listo_2, listo, busy, error}
    typedef struct {
        logic        kv;
        logic [3:0]  kc;
        logic        md;
        logic [21:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [21:0] ex(input logic [7:0] n1, input logic [7:0] n2,
                                       input logic ms, input logic l1, input logic l2,
                                       input logic l, input logic b, input logic e);
        return {n1, n2, ms, l1, l2, l, b, e};
    endfunction

    function automatic logic [21:0] outs();
        return {num_1, num_2, mul_start, listo_1, listo_2, listo, busy, error};
    endfunction

    task automatic check(input string name, input logic [21:0] exp);
        logic [21:0] act;
        act = outs();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got n1=%0d n2=%0d flags=%b, want n1=%0d n2=%0d flags=%b",
                     name, act[21:14], act[13:6], act[5:0], exp[21:14], exp[13:6], exp[5:0]);
        end
    endtask

    // One clock with the given inputs; outputs are sampled 1 time unit after the edge.
    task automatic step(input logic kv, input logic [3:0] kc, input logic md);
        key_valid = kv;
        key_code  = kc;
        mul_done  = md;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        key_code  = 4'h0;
        mul_done  = 1'b0;
    endtask

    task automatic key(input logic [3:0] kc);
        step(1'b1, kc, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 4'h0, 1'b0);
    endtask

    // Enter single-digit A and B and stop in the start cycle.
    task automatic go_to_start(input logic [3:0] a, input logic [3:0] b);
        key(a);
        key(4'hA);
        key(b);
        key(4'hA);
    endtask

    initial begin
        // Main table, applied straight after reset.
        vecs.push_back('{1'b1, 4'h1, 1'b0, ex(8'd1, 8'd0, 0, 0, 0, 0, 0, 0)});
        vecs.push_back('{1'b1, 4'h2, 1'b0, ex(8'd12, 8'd0, 0, 0, 0, 0, 0, 0)});
        vecs.push_back('{1'b1, 4'hA, 1'b0, ex(8'd12, 8'd0, 0, 1, 0, 0, 0, 0)});
        vecs.push_back('{1'b1, 4'h3, 1'b0, ex(8'd12, 8'd3, 0, 1, 0, 0, 0, 0)});
        vecs.push_back('{1'b1, 4'hA, 1'b0, ex(8'd12, 8'd3, 1, 1, 1, 0, 1, 0)});
        for (int i = 0; i < 4; i++)
            vecs.push_back('{1'b0, 4'h0, 1'b0, ex(8'd12, 8'd3, 0, 1, 1, 0, 1, 0)});
        vecs.push_back('{1'b0, 4'h0, 1'b1, ex(8'd12, 8'd3, 0, 1, 1, 1, 0, 0)});
        vecs.push_back('{1'b0, 4'h0, 1'b0, ex(8'd12, 8'd3, 0, 1, 1, 1, 0, 0)});
        vecs.push_back('{1'b1, 4'hA, 1'b0, ex(8'd12, 8'd3, 0, 1, 1, 1, 0, 0)});
        vecs.push_back('{1'b1, 4'h7, 1'b0, ex(8'd7, 8'd0, 0, 0, 0, 0, 0, 0)});
        vecs.push_back('{1'b1, 4'hB, 1'b0, ex(8'd0, 8'd0, 0, 0, 0, 0, 0, 0)});
        vecs.push_back('{1'b1, 4'h2, 1'b0, ex(8'd2, 8'd0, 0, 0, 0, 0, 0, 0)});
        vecs.push_back('{1'b1, 4'h5, 1'b0, ex(8'd25, 8'd0, 0, 0, 0, 0, 0, 0)});
        vecs.push_back('{1'b1, 4'h6, 1'b0, ex(8'd25, 8'd0, 0, 0, 0, 0, 0, 0)});
        vecs.push_back('{1'b1, 4'hB, 1'b0, ex(8'd0, 8'd0, 0, 0, 0, 0, 0, 0)});
        vecs.push_back('{1'b1, 4'h2, 1'b0, ex(8'd2, 8'd0, 0, 0, 0, 0, 0, 0)});
        vecs.push_back('{1'b1, 4'h5, 1'b0, ex(8'd25, 8'd0, 0, 0, 0, 0, 0, 0)});
        vecs.push_back('{1'b1, 4'h5, 1'b0, ex(8'd255, 8'd0, 0, 0, 0, 0, 0, 0)});
        vecs.push_back('{1'b1, 4'hB, 1'b0, ex(8'd0, 8'd0, 0, 0, 0, 0, 0, 0)});
        vecs.push_back('{1'b1, 4'h9, 1'b0, ex(8'd9, 8'd0, 0, 0, 0, 0, 0, 0)});
        vecs.push_back('{1'b1, 4'h9, 1'b0, ex(8'd99, 8'd0, 0, 0, 0, 0, 0, 0)});
        vecs.push_back('{1'b1, 4'h9, 1'b0, ex(8'd99, 8'd0, 0, 0, 0, 0, 0, 0)});
        vecs.push_back('{1'b1, 4'h9, 1'b0, ex(8'd99, 8'd0, 0, 0, 0, 0, 0, 0)});
        vecs.push_back('{1'b1, 4'hB, 1'b0, ex(8'd0, 8'd0, 0, 0, 0, 0, 0, 0)});
        vecs.push_back('{1'b1, 4'hA, 1'b0, ex(8'd0, 8'd0, 0, 0, 0, 0, 0, 0)});
        vecs.push_back('{1'b1, 4'hC, 1'b0, ex(8'd0, 8'd0, 0, 0, 0, 0, 0, 0)});
        vecs.push_back('{1'b1, 4'h4, 1'b0, ex(8'd4, 8'd0, 0, 0, 0, 0, 0, 0)});
        vecs.push_back('{1'b1, 4'hA, 1'b0, ex(8'd4, 8'd0, 0, 1, 0, 0, 0, 0)});
        vecs.push_back('{1'b1, 4'hA, 1'b0, ex(8'd4, 8'd0, 0, 1, 0, 0, 0, 0)});
        vecs.push_back('{1'b1, 4'hF, 1'b0, ex(8'd4, 8'd0, 0, 1, 0, 0, 0, 0)});
        vecs.push_back('{1'b1, 4'h0, 1'b0, ex(8'd4, 8'd0, 0, 1, 0, 0, 0, 0)});
        vecs.push_back('{1'b1, 4'hB, 1'b0, ex(8'd0, 8'd0, 0, 0, 0, 0, 0, 0)});
        vecs.push_back('{1'b0, 4'h0, 1'b1, ex(8'd0, 8'd0, 0, 0, 0, 0, 0, 0)});

        // Reset state
        #12;
        check("reset_hold", ex(8'd0, 8'd0, 0, 0, 0, 0, 0, 0));
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("after_reset", ex(8'd0, 8'd0, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].kv, vecs[i].kc, vecs[i].md);
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Timeout: error appears exactly MUL_TIMEOUT cycles after entering the wait state.
        go_to_start(4'h1, 4'h2);
        idle();
        check("to_wait_entry", ex(8'd1, 8'd2, 0, 1, 1, 0, 1, 0));
        for (int k = 1; k <= int'(MUL_TIMEOUT); k++) begin
            idle();
            if (k == int'(MUL_TIMEOUT))
                check("to_error", ex(8'd1, 8'd2, 0, 0, 0, 0, 0, 1));
            else
                check($sformatf("to_wait%0d", k), ex(8'd1, 8'd2, 0, 1, 1, 0, 1, 0));
        end
        key(4'h5);
        check("to_digit_ignored", ex(8'd1, 8'd2, 0, 0, 0, 0, 0, 1));
        step(1'b0, 4'h0, 1'b1);
        check("to_done_ignored", ex(8'd1, 8'd2, 0, 0, 0, 0, 0, 1));
        key(4'hB);
        check("to_clear", ex(8'd0, 8'd0, 0, 0, 0, 0, 0, 0));

        // Done coincident with the last timeout cycle wins.
        go_to_start(4'h3, 4'h4);
        idle();
        for (int k = 1; k < int'(MUL_TIMEOUT); k++) idle();
        check("co_last_wait", ex(8'd3, 8'd4, 0, 1, 1, 0, 1, 0));
        step(1'b0, 4'h0, 1'b1);
        check("co_done_wins", ex(8'd3, 8'd4, 0, 1, 1, 1, 0, 0));
        key(4'hB);
        check("co_clear", ex(8'd0, 8'd0, 0, 0, 0, 0, 0, 0));

        // Abort in the wait state, then a late done must not move the FSM.
        go_to_start(4'h5, 4'h6);
        idle();
        idle();
        key(4'hB);
        check("ab_clear", ex(8'd0, 8'd0, 0, 0, 0, 0, 0, 0));
        step(1'b0, 4'h0, 1'b1);
        check("ab_late_done", ex(8'd0, 8'd0, 0, 0, 0, 0, 0, 0));
        idle();
        check("ab_settled", ex(8'd0, 8'd0, 0, 0, 0, 0, 0, 0));

        // Asynchronous reset while mul_start is high.
        go_to_start(4'h8, 4'h9);
        check("rs_in_start", ex(8'd8, 8'd9, 1, 1, 1, 0, 1, 0));
        #2;
        rst = 1'b1;
        #1;
        check("rs_immediate", ex(8'd0, 8'd0, 0, 0, 0, 0, 0, 0));
        #3;
        rst = 1'b0;
        idle();
        check("rs_after", ex(8'd0, 8'd0, 0, 0, 0, 0, 0, 0));
        key(4'h6);
        check("rs_new_digit", ex(8'd6, 8'd0, 0, 0, 0, 0, 0, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/module_ctrl_calc.md
Name: module_ctrl_calc

Overview:
- Sequencing FSM for the keypad-multiplier calculator.
- Builds operand A and operand B from decimal keypad digits and launches the multiplier with a one-cycle start pulse.
- Waits for the multiplier's done signal, with a timeout.
- Drives the listo_1/listo_2/listo flags consumed by the display priority selector, so the 7-segment path shows the operand under entry or the product.

Parameters:
MAX_DIGITS, 3, max decimal digits accepted per operand (leading zeros count)
MUL_TIMEOUT, 64, cycles allowed in S_WAIT before error; counter width $clog2(MUL_TIMEOUT)+1

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
key_valid  input  1  one-cycle pulse, key_code valid
key_code  input  4  0x0-0x9 digit, 0xA enter, 0xB clear, 0xC-0xF ignored
mul_done  input  1  multiplier result valid (level or pulse; sampled only in S_WAIT)
num_1  output  8  operand A, unsigned binary
num_2  output  8  operand B, unsigned binary
mul_start  output  1  one-cycle start pulse to multiplier
listo_1  output  1  operand A complete
listo_2  output  1  operand B complete
listo  output  1  product valid for display
busy  output  1  multiplication in flight
error  output  1  multiplier timeout

Behaviour:
- Async reset behaviour:
  - state=S_A; num_1=num_2=0; digit counters=0; timeout counter=0.
  - All flag outputs are 0.
- All outputs are registered. A key sampled at edge N is reflected on outputs after edge N (1-cycle latency).
- Digit accumulation, active operand only:
  - tmp = acc*10 + digit, computed at 12 bits.
  - Accept only if digit count < MAX_DIGITS and tmp <= 255. Otherwise ignore the key with no state change.
  - On accept, acc <= tmp[7:0] and count++.
- States and transitions:
  - S_A (entering A):
    - digit -> accumulate into num_1.
    - enter with count_A>=1 -> S_B.
    - enter with count_A=0 -> ignored.
    - clear -> zero num_1, num_2, counters; stay in S_A.
  - S_B (entering B):
    - digit -> num_2.
    - enter with count_B>=1 -> S_START.
    - enter with count_B=0 -> ignored.
    - clear -> full clear, go to S_A.
  - S_START: mul_start=1 for exactly this one cycle; keys ignored; unconditional -> S_WAIT.
  - S_WAIT:
    - Timeout counter increments each cycle.
    - mul_done=1 -> S_RES.
    - Counter reaches MUL_TIMEOUT-1 without done -> S_ERR.
    - clear -> full clear, go to S_A (abort).
    - Other keys ignored.
    - If mul_done and timeout occur in the same cycle, mul_done wins.
  - S_RES:
    - digit -> full clear, then that digit loaded as the first digit of num_1, go to S_A.
    - clear -> full clear, go to S_A.
    - enter ignored.
  - S_ERR:
    - Only clear is honoured -> full clear, go to S_A.
    - Other keys ignored.
- Flag decode (registered from next state):
  - listo_1 = S_B | S_START | S_WAIT | S_RES
  - listo_2 = S_START | S_WAIT | S_RES
  - listo = S_RES
  - busy = S_START | S_WAIT
  - error = S_ERR
- num_1/num_2 hold their values through S_START..S_RES; the multiplier samples them at the mul_start cycle.
- mul_done outside S_WAIT is ignored. A late done after an abort must not move the FSM.
- key_valid held high for several cycles counts as one key per cycle. Debouncing is upstream.
- Timeout counter is cleared on entry to S_START.
- Reset mid-operation returns to the reset state immediately, with no mul_start glitch.

Test Plan:
- Keys 1,2,enter,3,enter; mul_done asserted 5 cycles after mul_start:
  - num_1=12; listo_1 rises after first enter; num_2=3.
  - mul_start high exactly 1 cycle; busy=1 until done.
  - listo=1 held in S_RES; listo_1=listo_2=1.
- Keys 2,5,6 then 2,5,5 then 9,9,9,9:
  - 256 rejected: num_1=25 after "256" attempt.
  - Fresh clear, then 2,5,5 -> num_1=255.
  - Clear, then 9,9,9,9 -> num_1=99: 999 rejected (>255), so third 9 and fourth 9 both rejected.
- enter with no digits in S_A and S_B -> no transition; listo_1 stays 0 / listo_2 stays 0.
- No mul_done after start -> error=1 exactly MUL_TIMEOUT cycles after S_WAIT entry; busy=0; digit ignored; clear -> all outputs 0.
- Timeout and other boundaries:
  - mul_done coincident with last timeout cycle -> S_RES, error stays 0.
  - clear in S_WAIT, then mul_done pulse -> FSM stays in S_A, listo=0.
- Async reset:
  - In S_RES, key 7 -> state S_A, num_1=7, num_2=0, listo=0.
  - rst asserted mid-cycle in S_START -> mul_start and all flags 0 immediately; num_1=num_2=0.
